instr_encode_loader: RTL and testbench
======================================

// Module: instr_encode_loader
// PURPOSE
//  Inverse of the instruction decoder: packs MIPS field tuples (R/I/J or raw)
//  into 32-bit instruction words and streams them into instruction memory
//  through a write port, one word per accepted handshake. Used as the program
//  loader ahead of fetch; the memory contents round-trip through the decoder.
// PARAMETERS
//  ADDR_WIDTH  10  instruction-memory word-address width
//  BASE_ADDR   0   first word address written after reset/clear
//  DEPTH       1024 max words loadable (DEPTH <= 2**ADDR_WIDTH)
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   asynchronous active-low reset
//  clear      in   1   sync restart: ptr<=BASE_ADDR, count<=0, flags cleared
//  in_valid   in   1   field tuple valid
//  in_ready   out  1   loader can accept tuple this cycle
//  in_last    in   1   tuple is final word of program
//  fmt        in   2   00=R 01=I 10=J 11=raw
//  opcode     in   6   ; rs, rt, rd, shamt in 5 each; funct in 6
//  imm16      in   16  I-format immediate
//  address    in   26  J-format target
//  raw        in   32  word used verbatim when fmt=11
//  mem_we     out  1   memory write strobe (one cycle per word)
//  mem_addr   out  ADDR_WIDTH  word address of write
//  mem_wdata  out  32  encoded instruction
//  count      out  ADDR_WIDTH+1  words written since reset/clear
//  full       out  1   count==DEPTH
//  done       out  1   in_last word written; loader idle
//  fmt_err    out  1   sticky: R with opcode!=0, or J with opcode not 2/3
// BEHAVIOUR
//  - Encode: R={opcode,rs,rt,rd,shamt,funct}; I={opcode,rs,rt,imm16};
//    J={opcode,address}; raw=raw. Unused fields ignored.
//  - FSM: LOAD -> DONE. LOAD: in_ready=!full&&!clear. DONE: in_ready=0.
//  - Handshake = in_valid&&in_ready at rising edge N. At edge N register
//    mem_wdata=enc, mem_addr=ptr, mem_we=1 (high cycle N..N+1), ptr++, count++.
//    Latency 1 cycle; back-to-back accepts give consecutive addresses.
//  - No handshake at edge -> mem_we<=0; mem_addr/mem_wdata hold.
//  - in_last on handshake: state<=DONE, done<=1 with same edge as mem_we.
//  - full: in_ready=0; in_valid stalls indefinitely; no write, no wrap.
//    Word written when count reaches DEPTH is kept; ptr not wrapped.
//  - fmt_err set on accepted offending tuple; word still written as encoded.
//  - clear (any state) beats simultaneous in_valid: no accept, state<=LOAD,
//    mem_we<=0, done<=0, fmt_err<=0; mem_addr/mem_wdata hold.
//  - reset_n low (async, incl. mid-stream): state=LOAD, ptr=BASE_ADDR,
//    count=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, fmt_err=0,
//    full=0. in_ready=1 from first cycle after release.
// CONFIGURATION
//  INSTR_ENC_CHECKSUM_EN defined: extra port checksum out 32 = XOR of all
//    written mem_wdata; updated same edge as write; 0 on reset/clear.
//  Undefined: no checksum port or logic; all other behaviour identical.
// TESTING
//  1 R: fmt=00 op=0 rs=11 rt=24 rd=4 sh=0 fn=20h -> mem_wdata=01782020h,
//    mem_addr=BASE_ADDR, mem_we 1 cycle, count=1.
//  2 I then J back-to-back: op=8 rs=0 rt=8 imm=5 -> 20080005h @BASE;
//    op=2 addr=0100000h -> 08100000h @BASE+1; fmt_err stays 0.
//  3 DEPTH=4, 5 tuples held valid -> 4 writes, full=1, in_ready=0, 5th never
//    written; clear -> count=0, in_ready=1, next write @BASE_ADDR.
//  4 in_last on 3rd word -> done=1, in_ready=0; further in_valid ignored.
//  5 fmt=00 op=23h -> word written, fmt_err=1 until clear; clear+in_valid same
//    cycle -> no write. reset_n low mid-stream -> all outputs reset values.
//  6 CHECKSUM_EN: write 01782020h, 20080005h -> checksum=21702025h.

Source files
------------

// File: rtl/instr_encode_loader_if.sv
// instr_encode_loader_if: field-tuple input stream and instruction-memory write port
interface instr_encode_loader_if #(parameter int ADDR_WIDTH = 10);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [1:0]            fmt;
    logic [5:0]            opcode;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic [5:0]            funct;
    logic [15:0]           imm16;
    logic [25:0]           address;
    logic [31:0]           raw;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    modport master (
        output in_valid, in_last, fmt, opcode, rs, rt, rd, shamt, funct, imm16, address, raw,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  in_valid, in_last, fmt, opcode, rs, rt, rd, shamt, funct, imm16, address, raw,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs MIPS R/I/J/raw tuples into words and streams them to instruction memory
// Optional checksum output enabled by defining INSTR_ENC_CHECKSUM_EN.
module instr_encode_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    instr_encode_loader_if.slave  bus,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  done,
    output logic                  fmt_err
`ifdef INSTR_ENC_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);
    typedef enum logic {LOAD, DONE} state_t;
    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [31:0]           enc;
    logic                  bad;
    logic                  acc;
    // encode the presented tuple and flag opcodes illegal for its format
    always_comb begin
        enc = bus.fmt == 2'b00 ? {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct} :
              bus.fmt == 2'b01 ? {bus.opcode, bus.rs, bus.rt, bus.imm16} :
              bus.fmt == 2'b10 ? {bus.opcode, bus.address} : bus.raw;
        bad = bus.fmt == 2'b00 ? bus.opcode != 6'd0 :
              bus.fmt == 2'b10 ? bus.opcode != 6'd2 && bus.opcode != 6'd3 : 1'b0;
    end
    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= LOAD;
        else          state <= state_nxt;
    // next state: clear always returns to LOAD, the last accepted word ends loading
    always_comb state_nxt = clear ? LOAD : (acc && bus.in_last) ? DONE : state;
    // outputs: clear and full both block acceptance
    always_comb begin
        full         = count == (ADDR_WIDTH+1)'(DEPTH);
        bus.in_ready = state == LOAD && !full && !clear;
        done         = state == DONE;
        acc          = bus.in_valid && bus.in_ready;
    end
    // write port, pointer, word count and sticky format error
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ptr           <= ADDR_WIDTH'(BASE_ADDR);
            count         <= '0;
            fmt_err       <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
            bus.mem_wdata <= '0;
        end else if (clear) begin
            ptr        <= ADDR_WIDTH'(BASE_ADDR);
            count      <= '0;
            fmt_err    <= 1'b0;
            bus.mem_we <= 1'b0;
        end else begin
            bus.mem_we <= acc;
            if (acc) begin
                bus.mem_addr  <= ptr;
                bus.mem_wdata <= enc;
                ptr           <= ptr + 1'b1;
                count         <= count + 1'b1;
                fmt_err       <= fmt_err | bad;
            end
        end
`ifdef INSTR_ENC_CHECKSUM_EN
    // running XOR of every written word
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)   checksum <= '0;
        else if (clear) checksum <= '0;
        else if (acc)   checksum <= checksum ^ enc;
`endif
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: directed and randomized checks against a behavioural loader model
module tb_instr_encode_loader;
    localparam int AW = 4, BASE = 3, DEPTH = 4;
    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] ad;
        logic [31:0] raw;
    } tuple_t;
    logic clk = 0, reset_n = 0, clear = 0;
    logic [AW:0] count;
    logic full, done, fmt_err;
`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0] checksum;
`endif
    instr_encode_loader_if #(.ADDR_WIDTH(AW)) bus ();
    instr_encode_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus),
        .count(count), .full(full), .done(done), .fmt_err(fmt_err)
`ifdef INSTR_ENC_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0;
    int m_count;
    bit m_done, m_err, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0] m_wdata, m_sum;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask
    function automatic logic [31:0] encode(input tuple_t t);
        case (t.fmt)
            2'd0: return (32'(t.op) << 26) | (32'(t.rs) << 21) | (32'(t.rt) << 16) |
                         (32'(t.rd) << 11) | (32'(t.sh) << 6) | 32'(t.fn);
            2'd1: return (32'(t.op) << 26) | (32'(t.rs) << 21) | (32'(t.rt) << 16) | 32'(t.imm);
            2'd2: return (32'(t.op) << 26) | 32'(t.ad);
            default: return t.raw;
        endcase
    endfunction
    function automatic bit illegal(input tuple_t t);
        if (t.fmt == 2'd0) return t.op != 0;
        if (t.fmt == 2'd2) return !(t.op == 2 || t.op == 3);
        return 0;
    endfunction
    function automatic tuple_t rnd_tuple();
        tuple_t t;
        t.fmt = 2'($urandom_range(0, 3));
        t.op  = $urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
        t.rs = 5'($urandom); t.rt = 5'($urandom); t.rd = 5'($urandom); t.sh = 5'($urandom);
        t.fn = 6'($urandom); t.imm = 16'($urandom); t.ad = 26'($urandom); t.raw = $urandom;
        return t;
    endfunction
    function automatic tuple_t mk(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                                  input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] ad);
        tuple_t t;
        t = rnd_tuple();
        t.fmt = f; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd; t.sh = sh; t.fn = fn; t.imm = imm; t.ad = ad;
        return t;
    endfunction
    task automatic model_reset();
        m_count = 0; m_done = 0; m_err = 0; m_we = 0;
        m_addr = AW'(BASE); m_wdata = 0; m_sum = 0;
    endtask
    task automatic check_outputs();
        check("mem_we", bus.mem_we, m_we);
        check("mem_addr", bus.mem_addr, m_addr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
        check("count", count, m_count);
        check("full", full, m_count == DEPTH);
        check("done", done, m_done);
        check("fmt_err", fmt_err, m_err);
`ifdef INSTR_ENC_CHECKSUM_EN
        check("checksum", checksum, m_sum);
`endif
    endtask
    task automatic drive(input tuple_t t, input logic v, input logic last, input logic clr);
        bit rdy;
        logic [31:0] e;
        bus.in_valid = v; bus.in_last = last; clear = clr;
        bus.fmt = t.fmt; bus.opcode = t.op; bus.rs = t.rs; bus.rt = t.rt; bus.rd = t.rd;
        bus.shamt = t.sh; bus.funct = t.fn; bus.imm16 = t.imm; bus.address = t.ad; bus.raw = t.raw;
        #1;
        rdy = !m_done && m_count < DEPTH && !clr;
        check("in_ready", bus.in_ready, rdy);
        @(posedge clk);
        e = encode(t);
        if (clr) begin
            m_count = 0; m_done = 0; m_err = 0; m_we = 0; m_sum = 0;
        end else if (v && rdy) begin
            m_we = 1; m_addr = AW'(BASE + m_count); m_wdata = e;
            m_count++; m_sum ^= e;
            if (last) m_done = 1;
            if (illegal(t)) m_err = 1;
        end else m_we = 0;
        @(negedge clk);
        check_outputs();
    endtask
    task automatic do_reset();
        #2 reset_n = 0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset_n = 1;
        #1 check("in_ready_after_reset", bus.in_ready, 1'b1);
    endtask
    tuple_t idle, r1, i1, j1;
    initial begin
        idle = rnd_tuple();
        bus.in_valid = 0; bus.in_last = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        r1 = mk(2'd0, 6'd0, 5'd11, 5'd24, 5'd4, 5'd0, 6'h20, 16'h0, 26'h0);
        i1 = mk(2'd1, 6'd8, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'h0);
        j1 = mk(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0100000);
        drive(r1, 1, 0, 0);
        check("r_word", bus.mem_wdata, 32'h01782020);
        check("r_addr", bus.mem_addr, AW'(BASE));
        drive(idle, 0, 0, 0);
        drive(idle, 1, 0, 1);
        drive(i1, 1, 0, 0);
        check("i_word", bus.mem_wdata, 32'h20080005);
        drive(j1, 1, 0, 0);
        check("j_word", bus.mem_wdata, 32'h08100000);
        check("j_addr", bus.mem_addr, AW'(BASE + 1));
        drive(idle, 0, 0, 1);
        for (int i = 0; i < 7; i++) drive(rnd_tuple(), 1, 0, 0);
        check("full_flag", full, 1'b1);
        drive(idle, 1, 0, 1);
        drive(i1, 1, 0, 0);
        check("after_clear_addr", bus.mem_addr, AW'(BASE));
        drive(idle, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(rnd_tuple(), 1, i == 2, 0);
        check("done_flag", done, 1'b1);
        for (int i = 0; i < 3; i++) drive(rnd_tuple(), 1, 1, 0);
        drive(idle, 0, 0, 1);
        drive(mk(2'd0, 6'h23, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'd0, 26'd0), 1, 0, 0);
        check("fmt_err_set", fmt_err, 1'b1);
        drive(i1, 1, 0, 0);
        drive(r1, 1, 0, 1);
        drive(r1, 1, 0, 0);
        drive(i1, 1, 0, 0);
        do_reset();
        drive(idle, 0, 0, 1);
        drive(r1, 1, 0, 0);
        drive(i1, 1, 0, 0);
`ifdef INSTR_ENC_CHECKSUM_EN
        check("checksum_pair", checksum, 32'h21702025);
`endif
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) do_reset();
            drive(rnd_tuple(), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 8);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
